watch_display_scan: RTL



---
 rtl/watch_display_scan_pkg.sv | 81 ++++++++
 rtl/watch_display_scan_bin2bcd_seq.sv | 55 +++++
 rtl/watch_display_scan.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/watch_display_scan_pkg.sv
// Shared types, segment codes and helpers for the watch display scanner.
// Segment codes are 7-bit active-low {g,f,e,d,c,b,a}.
package watch_display_scan_pkg;

   localparam int NUM_DIGITS = 7;
   localparam int BLINK_W    = 15;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Digit code used for an invalid field; any code above 9 decodes to dash
   localparam logic [3:0] CODE_DASH = 4'hA;

   typedef enum logic [1:0] {
      BLINK_NONE = 2'b00,
      BLINK_SEC  = 2'b01,
      BLINK_MIN  = 2'b10,
      BLINK_HR   = 2'b11
   } blink_e;

   typedef enum logic [2:0] {
      CV_IDLE,
      CV_SEC,
      CV_MIN,
      CV_HR,
      CV_DONE
   } cv_state_e;

   // Frame snapshot; seconds are captured straight into the converter
   typedef struct packed {
      logic [7:0] min;
      logic [7:0] hr;
      logic [3:0] week;
      blink_e     blink;
   } snap_t;

   function automatic logic [6:0] seg7(input logic [3:0] c);
      logic [6:0] s;
      unique case (c)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   function automatic blink_e field_of(input logic [2:0] idx);
      blink_e f;
      unique case (idx)
         3'd0, 3'd1: f = BLINK_SEC;
         3'd2, 3'd3: f = BLINK_MIN;
         3'd4, 3'd5: f = BLINK_HR;
         default:    f = BLINK_NONE;
      endcase
      return f;
   endfunction

   // A non-zero hundreds digit means the binary value was above 99
   function automatic logic [7:0] fmt_field(input logic [11:0] bcd);
      return (|bcd[11:8]) ? {2{CODE_DASH}} : bcd[7:0];
   endfunction

endpackage

// File: rtl/watch_display_scan_bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble).
// Ports: clk_32_768K, rst_n, start, bin -> busy, done (1-clk pulse), bcd.
module watch_display_scan_bin2bcd_seq (
   input  logic        clk_32_768K,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  bin,
   output logic        busy,
   output logic        done,
   output logic [11:0] bcd
);

   logic [19:0] sh_q;
   logic [19:0] sh_adj;
   logic [2:0]  cnt_q;
   logic        busy_q;
   logic        done_q;

   // Add 3 to every BCD nibble >= 5 before the shift
   always_comb begin
      sh_adj = sh_q;
      for (int k = 0; k < 3; k++) begin
         if (sh_q[8+4*k +: 4] >= 4'd5)
            sh_adj[8+4*k +: 4] = sh_q[8+4*k +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk_32_768K or negedge rst_n) begin
      if (!rst_n) begin
         sh_q   <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (busy_q) begin
            sh_q  <= {sh_adj[18:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
            end
         end else if (start) begin
            sh_q   <= {12'd0, bin};
            cnt_q  <= '0;
            busy_q <= 1'b1;
         end
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = sh_q[19:8];

endmodule

// File: rtl/watch_display_scan.sv
// 7-digit multiplexed common-anode display driver (HH MM SS W).
// Ports: clk/rst_n, Sec/Min/HrBuffer, Blink, Week -> Seg, DigitSel.
module watch_display_scan
   import watch_display_scan_pkg::*;
#(
   parameter int SCAN_DIV_W = 5,
   parameter int BLINK_BIT  = 14
) (
   input  logic       clk_32_768K,
   input  logic       rst_n,
   input  logic [7:0] SecBuffer,
   input  logic [7:0] MinBuffer,
   input  logic [7:0] HrBuffer,
   input  logic [1:0] Blink,
   input  logic [3:0] Week,
   output logic [7:0] Seg,
   output logic [6:0] DigitSel
);

   logic [SCAN_DIV_W-1:0] dwell_q, dwell_d;
   logic [2:0]            idx_q, idx_d;
   logic [BLINK_W-1:0]    blink_q;

   snap_t      hold_q;
   cv_state_e  cv_q;
   logic [7:0] res_sec_q, res_min_q, res_hr_q;
   logic       conv_ok_q;

   logic [NUM_DIGITS-1:0][3:0] disp_q;
   blink_e                     disp_blink_q;
   logic                       disp_ok_q;

   logic [7:0] seg_q, seg_d;
   logic [6:0] dsel_q, dsel_d;

   logic        frame_start;
   logic        cvt_start, cvt_busy, cvt_done;
   logic [7:0]  cvt_bin;
   logic [11:0] cvt_bcd;

   assign frame_start = (idx_q == 3'd0) && (dwell_q == '0);

   always_comb begin
      dwell_d = dwell_q + 1'b1;
      idx_d   = idx_q;
      if (&dwell_q)
         idx_d = (idx_q == 3'(NUM_DIGITS-1)) ? 3'd0 : idx_q + 3'd1;
   end

   // Seconds convert from the live bus at frame start so that
   // all three runs finish before the next commit.
   always_comb begin
      cvt_bin = SecBuffer;
      if (!frame_start)
         cvt_bin = (cv_q == CV_SEC) ? hold_q.min : hold_q.hr;
   end

   assign cvt_start = ~cvt_busy &
      (frame_start | (cvt_done & ((cv_q == CV_SEC) | (cv_q == CV_MIN))));

   watch_display_scan_bin2bcd_seq u_b2b (
      .clk_32_768K (clk_32_768K),
      .rst_n       (rst_n),
      .start       (cvt_start),
      .bin         (cvt_bin),
      .busy        (cvt_busy),
      .done        (cvt_done),
      .bcd         (cvt_bcd)
   );

   always_ff @(posedge clk_32_768K or negedge rst_n) begin
      if (!rst_n) begin
         dwell_q <= '0;
         idx_q   <= '0;
         blink_q <= '0;
      end else begin
         dwell_q <= dwell_d;
         idx_q   <= idx_d;
         blink_q <= blink_q + 1'b1;
      end
   end

   // Snapshot, conversion sequencer and commit share one frame-start edge
   always_ff @(posedge clk_32_768K or negedge rst_n) begin
      if (!rst_n) begin
         cv_q         <= CV_IDLE;
         hold_q       <= '0;
         res_sec_q    <= '0;
         res_min_q    <= '0;
         res_hr_q     <= '0;
         conv_ok_q    <= 1'b0;
         disp_q       <= '0;
         disp_blink_q <= BLINK_NONE;
         disp_ok_q    <= 1'b0;
      end else if (frame_start) begin
         cv_q         <= CV_SEC;
         hold_q       <= '{min: MinBuffer, hr: HrBuffer,
                           week: Week, blink: blink_e'(Blink)};
         disp_q       <= {hold_q.week, res_hr_q, res_min_q, res_sec_q};
         disp_blink_q <= hold_q.blink;
         disp_ok_q    <= conv_ok_q;
      end else if (cvt_done) begin
         unique case (cv_q)
            CV_SEC: begin
               res_sec_q <= fmt_field(cvt_bcd);
               cv_q      <= CV_MIN;
            end
            CV_MIN: begin
               res_min_q <= fmt_field(cvt_bcd);
               cv_q      <= CV_HR;
            end
            CV_HR: begin
               res_hr_q  <= fmt_field(cvt_bcd);
               conv_ok_q <= 1'b1;
               cv_q      <= CV_DONE;
            end
            default: cv_q <= cv_q;
         endcase
      end
   end

   // Blank until a full conversion has been committed; DP stays lit
   always_comb begin
      logic blank;
      blank = ~disp_ok_q |
              (blink_q[BLINK_BIT] & (disp_blink_q != BLINK_NONE) &
               (field_of(idx_q) == disp_blink_q));
      seg_d  = 8'hFF;
      dsel_d = 7'h7F;
      if (dwell_q != '0) begin
         dsel_d    = ~(7'd1 << idx_q);
         seg_d[7]  = ~((idx_q == 3'd2) | (idx_q == 3'd4));
         seg_d[6:0] = blank ? SEG_BLANK : seg7(disp_q[idx_q]);
      end
   end

   always_ff @(posedge clk_32_768K or negedge rst_n) begin
      if (!rst_n) begin
         seg_q  <= 8'hFF;
         dsel_q <= 7'h7F;
      end else begin
         seg_q  <= seg_d;
         dsel_q <= dsel_d;
      end
   end

   assign Seg      = seg_q;
   assign DigitSel = dsel_q;

endmodule
